// File: rtl/masked_circle_engine.sv
// masked_circle_engine: midpoint circle rasteriser with per-octant masking and screen clipping.
// Ports: clk/rst (sync, active-high); start + centre_x/centre_y/radius/octant_mask/colour request
//   a draw, latched in IDLE; done is held until start drops; vga_x/vga_y/vga_colour/vga_plot
//   feed the downstream VGA adaptor, one registered pixel slot per clock, no back-pressure.
module masked_circle_engine #(
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120,
  parameter int XW       = 8,
  parameter int YW       = 7,
  parameter int RW       = 8,
  parameter int COLW     = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [XW-1:0]   centre_x,
  input  logic [YW-1:0]   centre_y,
  input  logic [RW-1:0]   radius,
  input  logic [7:0]      octant_mask,
  input  logic [COLW-1:0] colour,
  output logic            done,
  output logic [XW-1:0]   vga_x,
  output logic [YW-1:0]   vga_y,
  output logic [COLW-1:0] vga_colour,
  output logic            vga_plot
);

  // Two guard bits: one for sign, one so cx+r cannot overflow.
  localparam int MXY = (XW > YW) ? XW : YW;
  localparam int AW  = ((MXY > RW) ? MXY : RW) + 2;

  localparam logic signed [AW-1:0] ZERO_S = '0;
  localparam logic signed [AW-1:0] ONE_S  = AW'(1);
  localparam logic signed [AW-1:0] W_LIM  = AW'(SCREEN_W);
  localparam logic signed [AW-1:0] H_LIM  = AW'(SCREEN_H);

  typedef enum logic [2:0] {IDLE, INIT, PLOT, STEP, DONE} state_t;

  state_t                 state_q, state_d;
  logic [XW-1:0]          cx_q, cx_d;
  logic [YW-1:0]          cy_q, cy_d;
  logic [RW-1:0]          r_q, r_d;
  logic [7:0]             mask_q, mask_d;
  logic [COLW-1:0]        col_q, col_d;
  logic signed [AW-1:0]   ox_q, ox_d, oy_q, oy_d, crit_q, crit_d;
  logic [2:0]             slot_q, slot_d;
  logic                   plot_q, plot_d, done_q, done_d;
  logic [XW-1:0]          x_q, x_d;
  logic [YW-1:0]          y_q, y_d;
  logic [COLW-1:0]        vcol_q, vcol_d;

  logic signed [AW-1:0]   cx_s, cy_s, rad_s, px, py, ox_n, oy_n;

  assign cx_s  = $signed({{(AW-XW){1'b0}}, cx_q});
  assign cy_s  = $signed({{(AW-YW){1'b0}}, cy_q});
  assign rad_s = $signed({{(AW-RW){1'b0}}, r_q});

  // Slot -> octant coordinate, signed so off-screen values are clipped, not wrapped.
  always_comb begin
    px = cx_s;
    py = cy_s;
    unique case (slot_q)
      3'd0: begin px = cx_s + ox_q; py = cy_s + oy_q; end
      3'd1: begin px = cx_s + oy_q; py = cy_s + ox_q; end
      3'd2: begin px = cx_s - ox_q; py = cy_s + oy_q; end
      3'd3: begin px = cx_s - oy_q; py = cy_s + ox_q; end
      3'd4: begin px = cx_s - ox_q; py = cy_s - oy_q; end
      3'd5: begin px = cx_s - oy_q; py = cy_s - ox_q; end
      3'd6: begin px = cx_s + ox_q; py = cy_s - oy_q; end
      default: begin px = cx_s + oy_q; py = cy_s - ox_q; end
    endcase
  end

  always_comb begin
    state_d = state_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    r_d     = r_q;
    mask_d  = mask_q;
    col_d   = col_q;
    ox_d    = ox_q;
    oy_d    = oy_q;
    crit_d  = crit_q;
    slot_d  = slot_q;
    plot_d  = 1'b0;
    x_d     = x_q;
    y_d     = y_q;
    vcol_d  = vcol_q;
    oy_n    = oy_q + ONE_S;
    ox_n    = (crit_q <= ZERO_S) ? ox_q : ox_q - ONE_S;
    // done lags the DONE state by one register stage.
    done_d  = (state_q == DONE);

    unique case (state_q)
      IDLE: begin
        if (start) begin
          cx_d    = centre_x;
          cy_d    = centre_y;
          r_d     = radius;
          mask_d  = octant_mask;
          col_d   = colour;
          state_d = INIT;
        end
      end
      INIT: begin
        ox_d    = rad_s;
        oy_d    = ZERO_S;
        crit_d  = ONE_S - rad_s;
        slot_d  = 3'd0;
        state_d = PLOT;
      end
      PLOT: begin
        // Masked/clipped slots still take their cycle: latency is data-independent.
        plot_d = mask_q[slot_q] && (px >= ZERO_S) && (px < W_LIM) &&
                 (py >= ZERO_S) && (py < H_LIM);
        x_d    = px[XW-1:0];
        y_d    = py[YW-1:0];
        vcol_d = col_q;
        slot_d = slot_q + 3'd1;
        if (slot_q == 3'd7) state_d = STEP;
      end
      STEP: begin
        oy_d = oy_n;
        ox_d = ox_n;
        if (crit_q <= ZERO_S) crit_d = crit_q + (oy_n <<< 1) + ONE_S;
        else                  crit_d = crit_q + ((oy_n - ox_n) <<< 1) + ONE_S;
        slot_d  = 3'd0;
        state_d = (oy_n <= ox_n) ? PLOT : DONE;
      end
      default: begin
        if (!start) state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cx_q    <= '0;
      cy_q    <= '0;
      r_q     <= '0;
      mask_q  <= '0;
      col_q   <= '0;
      ox_q    <= '0;
      oy_q    <= '0;
      crit_q  <= '0;
      slot_q  <= '0;
      plot_q  <= 1'b0;
      done_q  <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      vcol_q  <= '0;
    end else begin
      state_q <= state_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      r_q     <= r_d;
      mask_q  <= mask_d;
      col_q   <= col_d;
      ox_q    <= ox_d;
      oy_q    <= oy_d;
      crit_q  <= crit_d;
      slot_q  <= slot_d;
      plot_q  <= plot_d;
      done_q  <= done_d;
      x_q     <= x_d;
      y_q     <= y_d;
      vcol_q  <= vcol_d;
    end
  end

  assign done       = done_q;
  assign vga_plot   = plot_q;
  assign vga_x      = x_q;
  assign vga_y      = y_q;
  assign vga_colour = vcol_q;

endmodule

// File: tb/tb_masked_circle_engine.sv
// Bench for masked_circle_engine: expected pixels are queued when a draw is requested and
// popped as the DUT plots; latency, plot count and done handshake are checked per draw.
module tb_masked_circle_engine;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] centre_x = '0;
  logic [6:0] centre_y = '0;
  logic [7:0] radius = '0;
  logic [7:0] octant_mask = '0;
  logic [2:0] colour = '0;
  logic       done;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;

  masked_circle_engine dut (
    .clk(clk), .rst(rst), .start(start),
    .centre_x(centre_x), .centre_y(centre_y), .radius(radius),
    .octant_mask(octant_mask), .colour(colour),
    .done(done), .vga_x(vga_x), .vga_y(vga_y),
    .vga_colour(vga_colour), .vga_plot(vga_plot)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
  } pix_t;

  pix_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   plots = 0;
  bit   ignore_plots = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic push_pix(input int x, input int y, input logic [2:0] c);
    pix_t p;
    p.x = x[7:0];
    p.y = y[6:0];
    p.c = c;
    exp_q.push_back(p);
  endtask

  // Reference midpoint rasteriser; returns the number of loop iterations.
  task automatic model(input int cx, input int cy, input int r, input logic [7:0] m,
                       input logic [2:0] c, output int n);
    int ox, oy, crit, px, py;
    ox = r; oy = 0; crit = 1 - r; n = 0;
    do begin
      n++;
      for (int s = 0; s < 8; s++) begin
        case (s)
          0: begin px = cx + ox; py = cy + oy; end
          1: begin px = cx + oy; py = cy + ox; end
          2: begin px = cx - ox; py = cy + oy; end
          3: begin px = cx - oy; py = cy + ox; end
          4: begin px = cx - ox; py = cy - oy; end
          5: begin px = cx - oy; py = cy - ox; end
          6: begin px = cx + ox; py = cy - oy; end
          default: begin px = cx + oy; py = cy - ox; end
        endcase
        if (m[s] && px >= 0 && px < 160 && py >= 0 && py < 120) push_pix(px, py, c);
      end
      oy++;
      if (crit <= 0) crit = crit + 2 * oy + 1;
      else begin ox--; crit = crit + 2 * (oy - ox) + 1; end
    end while (oy <= ox);
  endtask

  always @(negedge clk) begin
    if (vga_plot === 1'b1 && !ignore_plots) begin
      pix_t p;
      plots++;
      check_val("plot_bounds", {30'd0, (vga_x < 8'd160), (vga_y < 7'd120)}, 32'd3);
      if (exp_q.size() == 0) begin
        check_val("unexpected_plot", 32'd1, 32'd0);
      end else begin
        p = exp_q.pop_front();
        check_val("plot_x", {24'd0, vga_x}, {24'd0, p.x});
        check_val("plot_y", {25'd0, vga_y}, {25'd0, p.y});
        check_val("plot_colour", {29'd0, vga_colour}, {29'd0, p.c});
      end
    end
  end

  // Launches a draw whose expected pixels are already queued, then checks latency,
  // pixel count and the done handshake.
  task automatic run_draw(input string tag, input int cx, input int cy, input int r,
                          input logic [7:0] m, input logic [2:0] c, input int n_iter,
                          output int lat);
    int exp_plots;
    exp_plots = exp_q.size();
    plots = 0;
    @(negedge clk);
    centre_x = cx[7:0]; centre_y = cy[6:0]; radius = r[7:0];
    octant_mask = m; colour = c; start = 1'b1;
    lat = -1;
    @(posedge clk); #1; lat = 0;
    // Post-latch input changes must be ignored.
    centre_x = ~centre_x; centre_y = 7'd5; radius = 8'd77; octant_mask = ~m; colour = ~c;
    while (done !== 1'b1 && lat < 20000) begin
      @(posedge clk); #1; lat++;
    end
    check_val({tag, "_latency"}, lat, 2 + 9 * n_iter);
    check_val({tag, "_plots"}, plots, exp_plots);
    check_val({tag, "_queue_empty"}, exp_q.size(), 0);
    repeat (3) @(posedge clk);
    #1 check_val({tag, "_done_held"}, {31'd0, done}, 32'd1);
    @(negedge clk); start = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    check_val({tag, "_done_fall"}, {31'd0, done}, 32'd0);
    repeat (2) @(posedge clk);
  endtask

  initial begin
    int n, lat, lat_ff, lat_00;

    // Reset, then idle.
    rst = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      check_val("rst_done", {31'd0, done}, 32'd0);
      check_val("rst_plot", {31'd0, vga_plot}, 32'd0);
    end
    check_val("rst_x", {24'd0, vga_x}, 32'd0);
    check_val("rst_y", {25'd0, vga_y}, 32'd0);
    check_val("rst_colour", {29'd0, vga_colour}, 32'd0);
    @(negedge clk); rst = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      check_val("idle_done", {31'd0, done}, 32'd0);
      check_val("idle_plot", {31'd0, vga_plot}, 32'd0);
    end

    // Radius 0: eight copies of the centre.
    repeat (8) push_pix(80, 60, 3'd5);
    run_draw("r0", 80, 60, 0, 8'hFF, 3'd5, 1, lat);

    // Radius 1: hand-derived pixel order, two iterations.
    push_pix(81, 60, 3'd2); push_pix(80, 61, 3'd2); push_pix(79, 60, 3'd2); push_pix(80, 61, 3'd2);
    push_pix(79, 60, 3'd2); push_pix(80, 59, 3'd2); push_pix(81, 60, 3'd2); push_pix(80, 59, 3'd2);
    push_pix(81, 61, 3'd2); push_pix(81, 61, 3'd2); push_pix(79, 61, 3'd2); push_pix(79, 61, 3'd2);
    push_pix(79, 59, 3'd2); push_pix(79, 59, 3'd2); push_pix(81, 59, 3'd2); push_pix(81, 59, 3'd2);
    run_draw("r1", 80, 60, 1, 8'hFF, 3'd2, 2, lat);

    // Masking: full, none, and the lower-right pair of slots.
    model(80, 60, 10, 8'hFF, 3'd7, n);
    run_draw("r10_ff", 80, 60, 10, 8'hFF, 3'd7, n, lat_ff);
    model(80, 60, 10, 8'h00, 3'd7, n);
    run_draw("r10_00", 80, 60, 10, 8'h00, 3'd7, n, lat_00);
    check_val("mask_latency_same", lat_00, lat_ff);
    model(80, 60, 10, 8'h03, 3'd1, n);
    run_draw("r10_03", 80, 60, 10, 8'h03, 3'd1, n, lat);

    // Clipping at the top-left corner; first iteration is only (10,0),(0,10),(0,10),(10,0).
    model(0, 0, 10, 8'hFF, 3'd4, n);
    check_val("clip_first_x", {24'd0, exp_q[0].x}, 32'd10);
    run_draw("clip_tl", 0, 0, 10, 8'hFF, 3'd4, n, lat);
    model(150, 115, 25, 8'hFF, 3'd6, n);
    run_draw("clip_br", 150, 115, 25, 8'hFF, 3'd6, n, lat);

    // Reset mid-draw, then a clean redraw.
    ignore_plots = 1'b1;
    @(negedge clk);
    centre_x = 8'd80; centre_y = 7'd60; radius = 8'd30; octant_mask = 8'hFF; start = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    check_val("midrst_plot", {31'd0, vga_plot}, 32'd0);
    check_val("midrst_done", {31'd0, done}, 32'd0);
    @(negedge clk); rst = 1'b0; start = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk); ignore_plots = 1'b0;
    model(80, 60, 30, 8'hFF, 3'd3, n);
    run_draw("after_rst", 80, 60, 30, 8'hFF, 3'd3, n, lat);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
